uart_rx_ovs: RTL
================

UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 10416, clk cycles per bit (legal values 8 or more).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal values 5..9).
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked (1 or 2).
REQ-005 SHALL have port clk, input, 1, the only clock.
REQ-006 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rxd, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port rdata, output, DATA_BITS, received word, LSB first on the line.
REQ-009 SHALL have port rvalid, output, 1, rdata, ferr and perr hold a word.
REQ-010 SHALL have port rready, input, 1, consumer accepts the word when rvalid and rready are both 1.
REQ-011 SHALL have port ferr, output, 1, stop-bit error for the held word.
REQ-012 SHALL have port perr, output, 1, parity error for the held word (always 0 when PARITY=0).
REQ-013 SHALL have port overrun, output, 1, one-cycle pulse when a completed frame is dropped.
REQ-014 SHALL have port brk, output, 1, one-cycle pulse on break detect (see REQ-027).

Function
REQ-015 rxd SHALL pass through a 2-flop synchronizer before any use.
REQ-016 A bit counter SHALL run 0..CLK_PER_BIT-1 within each bit, with H = CLK_PER_BIT/2.
REQ-017 Each bit SHALL be sampled at counts H-1, H and H+1, and its value is the majority vote, resolved at count H+1.
REQ-018 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-019 In IDLE, a synchronized low SHALL go to START and clear the counter in that cycle.
REQ-020 In START, a vote of 1 SHALL return to IDLE with no output (false start); a vote of 0 SHALL go to DATA.
REQ-021 DATA SHALL shift DATA_BITS votes into a shift register LSB-first, then go to PARITY if PARITY≠0, otherwise to STOP.
REQ-022 PARITY SHALL compare the vote with the XOR of the data bits (even: equal; odd: inverted), record perr, then go to STOP.
REQ-023 STOP SHALL vote STOP_BITS bits; ferr=1 if any stop vote is 0; the frame commits at count H+1 of the final stop bit (no wait for bit end).
REQ-024 On commit, if rvalid=0 or rready=1 in the same cycle, the block SHALL load rdata, ferr and perr and set rvalid=1 on the next edge.
REQ-025 On commit, if rvalid=1 and rready=0, the block SHALL keep the held word and pulse overrun for 1 cycle.
REQ-026 After commit, the FSM SHALL go to IDLE if ferr=0, or to WAIT_HIGH if ferr=1; WAIT_HIGH returns to IDLE on the first synchronized high.
REQ-027 An all-zero frame with ferr=1 (data, parity and stops all 0) SHALL be a break: pulse brk, no rvalid, no overrun, go to WAIT_HIGH.
REQ-028 rvalid SHALL clear on the edge after rvalid&&rready unless a commit occurs in the same cycle.
REQ-029 Latency from the final stop-bit sample point (count H+1) to rvalid high SHALL be 1 clk.

Reset
REQ-030 While rstn=0: state IDLE, counter 0, sync flops 1, rdata 0, rvalid 0, ferr 0, perr 0, overrun 0, brk 0.
REQ-031 Reset mid-frame SHALL discard the partial frame; after release, reception resumes only on a new falling edge.

Configuration
REQ-032 Macro UART_RX_BREAK_DET_EN defined: REQ-027 applies.
REQ-033 Macro UART_RX_BREAK_DET_EN absent: brk is tied 0, and an all-zero frame commits as an ordinary word with ferr=1.

Structure
REQ-034 Package uart_pkg SHALL hold the FSM state enum, the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the default CLK_PER_BIT.
REQ-035 Sub-module uart_sync_vote SHALL contain the synchronizer plus the 3-sample majority vote; the top module holds the FSM, counter and output register.

Verification (CLK_PER_BIT=16, DATA_BITS=8)
REQ-036 Send 0xA5 with PARITY=0 -> rvalid high 1 clk after the stop sample, rdata=0xA5, ferr=0, perr=0.
REQ-037 Send 0x3C with PARITY=1 and the parity bit flipped -> rdata=0x3C, perr=1.
REQ-038 Send 0x55 with rready=0, then 0x0F -> rdata stays 0x55, overrun pulses once; assert rready -> rvalid drops.
REQ-039 Pulse rxd low for 4 clks -> false start, no rvalid, FSM back in IDLE.
REQ-040 Hold rxd low for 2 frame times with the macro on -> exactly one brk pulse, no rvalid; a following 0x81 frame is received correctly.
REQ-041 Assert rstn=0 at data bit 3 of a frame -> all outputs 0 and no rvalid for the aborted frame.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared types and constants for the oversampling UART receiver.
//           Holds the receiver FSM state enum, the parity-mode encodings,
//           the default clocks-per-bit value and a majority-vote helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_e;

  // Parity-mode encodings for the PARITY parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Default clk cycles per bit
  localparam int DEF_CLK_PER_BIT = 10416;

  // 2-of-3 majority
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_vote.sv
`default_nettype none
// ============================================================================
// Module  : uart_sync_vote
// Purpose : Brings the asynchronous serial line into the clk domain through a
//           2-flop synchronizer and produces a 3-sample majority vote. Two
//           samples are captured on the early/mid strobes; the third is the
//           live synchronized value, so the vote is valid in the cycle after
//           the mid strobe.
// Ports   : clk        - clock
//           rstn       - asynchronous active-low reset
//           rxd        - raw serial line (idle high)
//           samp_early - capture first sample this cycle
//           samp_mid   - capture second sample this cycle
//           rxd_s      - synchronized line
//           vote       - majority of early, mid and current synchronized value
// Rev     : 1.0  initial release
// ============================================================================
module uart_sync_vote
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic rxd,
  input  logic samp_early,
  input  logic samp_mid,
  output logic rxd_s,
  output logic vote
);

  logic meta_q,    meta_d;
  logic sync_q,    sync_d;
  logic s_early_q, s_early_d;
  logic s_mid_q,   s_mid_d;

  always_comb begin
    meta_d    = rxd;
    sync_d    = meta_q;
    s_early_d = samp_early ? sync_q : s_early_q;
    s_mid_d   = samp_mid   ? sync_q : s_mid_q;
  end

  // Everything resets to the idle-high line level so no false start is seen
  // when reset is released.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q    <= 1'b1;
      sync_q    <= 1'b1;
      s_early_q <= 1'b1;
      s_mid_q   <= 1'b1;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      s_early_q <= s_early_d;
      s_mid_q   <= s_mid_d;
    end
  end

  assign rxd_s = sync_q;
  assign vote  = maj3(s_early_q, s_mid_q, sync_q);

endmodule
`default_nettype wire

// File: rtl/uart_rx_ovs.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_ovs
// Purpose : Oversampling UART receiver with majority-voted bit sampling,
//           optional parity, 1 or 2 stop bits, a one-word valid/ready output
//           register, overrun reporting and optional break detection.
// Config  : define UART_RX_BREAK_DET_EN to treat an all-zero frame with a
//           stop error as a break (brk pulse, no word). Without it, brk is
//           tied low and such a frame is delivered as a word with ferr=1.
// Ports   : clk     - clock
//           rstn    - asynchronous active-low reset
//           rxd     - asynchronous serial line, idle high
//           rdata   - received word (LSB first on the line)
//           rvalid  - rdata/ferr/perr hold a word
//           rready  - consumer accepts the word when rvalid && rready
//           ferr    - stop-bit error for the held word
//           perr    - parity error for the held word
//           overrun - 1-cycle pulse when a completed frame is dropped
//           brk     - 1-cycle pulse on break detect
// Rev     : 1.0  initial release
// ============================================================================
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = PAR_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rvalid,
  input  logic                 rready,
  output logic                 ferr,
  output logic                 perr,
  output logic                 overrun,
  output logic                 brk
);

  localparam int CNT_W  = $clog2(CLK_PER_BIT);
  localparam int H      = CLK_PER_BIT / 2;
  localparam int BIDX_W = 4;

  localparam logic [CNT_W-1:0]  CNT_LAST       = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_EARLY      = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0]  CNT_MID        = CNT_W'(H);
  localparam logic [CNT_W-1:0]  CNT_VOTE       = CNT_W'(H + 1);
  localparam logic [BIDX_W-1:0] BIDX_DATA_LAST = BIDX_W'(DATA_BITS - 1);
  localparam logic [BIDX_W-1:0] BIDX_STOP_LAST = BIDX_W'(STOP_BITS - 1);
  localparam logic              PAR_INV        = (PARITY == PAR_ODD);
  localparam bit                HAS_PARITY     = (PARITY != PAR_NONE);

`ifdef UART_RX_BREAK_DET_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  // FSM
  state_e state_q, state_d;

  // Frame datapath
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic [BIDX_W-1:0]    bidx_q,     bidx_d;
  logic [DATA_BITS-1:0] shreg_q,    shreg_d;
  logic                 par_bit_q,  par_bit_d;
  logic                 perr_f_q,   perr_f_d;
  logic                 stop_err_q, stop_err_d;
  logic                 stop_one_q, stop_one_d;

  // Output register
  logic [DATA_BITS-1:0] rdata_q,    rdata_d;
  logic                 rvalid_q,   rvalid_d;
  logic                 ferr_q,     ferr_d;
  logic                 perr_q,     perr_d;
  logic                 overrun_q,  overrun_d;
  logic                 brk_q,      brk_d;

  logic rxd_s;
  logic vote;
  logic vote_pt;
  logic commit;
  logic frame_ferr;
  logic all_zero;
  logic is_brk;
  logic load;

  uart_sync_vote u_sync_vote (
    .clk        (clk),
    .rstn       (rstn),
    .rxd        (rxd),
    .samp_early (cnt_q == CNT_EARLY),
    .samp_mid   (cnt_q == CNT_MID),
    .rxd_s      (rxd_s),
    .vote       (vote)
  );

  // The vote is resolved at count H+1; in IDLE/WAIT_HIGH the counter is
  // parked at 0, so this only fires inside a frame.
  assign vote_pt    = (cnt_q == CNT_VOTE);
  assign commit     = (state_q == ST_STOP) && vote_pt && (bidx_q == BIDX_STOP_LAST);
  assign frame_ferr = stop_err_q | ~vote;
  // Current vote is the final stop bit when this is evaluated at commit.
  assign all_zero   = (shreg_q == '0) && !par_bit_q && !stop_one_q && !vote;
  assign is_brk     = BRK_EN && commit && all_zero;
  assign load       = commit && !is_brk && (!rvalid_q || rready);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state. Transitions happen at the vote point of each bit; the
  // bit counter keeps free-running so the next bit's sample window lines up.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!rxd_s) state_d = ST_START;
      end
      ST_START: begin
        if (vote_pt) state_d = vote ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (vote_pt && (bidx_q == BIDX_DATA_LAST)) begin
          state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (vote_pt) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (commit) state_d = frame_ferr ? ST_WAIT_HIGH : ST_IDLE;
      end
      ST_WAIT_HIGH: begin
        if (rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM outputs: frame datapath and output register next values
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d      = cnt_q;
    bidx_d     = bidx_q;
    shreg_d    = shreg_q;
    par_bit_d  = par_bit_q;
    perr_f_d   = perr_f_q;
    stop_err_d = stop_err_q;
    stop_one_d = stop_one_q;

    case (state_q)
      ST_IDLE, ST_WAIT_HIGH: begin
        // Counter held at 0 so the start-detect cycle clears it.
        cnt_d      = '0;
        bidx_d     = '0;
        par_bit_d  = 1'b0;
        perr_f_d   = 1'b0;
        stop_err_d = 1'b0;
        stop_one_d = 1'b0;
      end
      default: begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
    endcase

    if (vote_pt) begin
      case (state_q)
        ST_DATA: begin
          shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
          bidx_d  = (bidx_q == BIDX_DATA_LAST) ? '0 : bidx_q + 1'b1;
        end
        ST_PARITY: begin
          par_bit_d = vote;
          perr_f_d  = vote ^ (^shreg_q) ^ PAR_INV;
        end
        ST_STOP: begin
          stop_err_d = stop_err_q | ~vote;
          stop_one_d = stop_one_q | vote;
          bidx_d     = bidx_q + 1'b1;
        end
        default: ;
      endcase
    end

    rdata_d   = load ? shreg_q    : rdata_q;
    ferr_d    = load ? frame_ferr : ferr_q;
    perr_d    = load ? perr_f_q   : perr_q;
    // A commit in the same cycle as a handshake keeps rvalid set.
    if (load) begin
      rvalid_d = 1'b1;
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
    overrun_d = commit && !is_brk && rvalid_q && !rready;
    brk_d     = is_brk;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      bidx_q     <= '0;
      shreg_q    <= '0;
      par_bit_q  <= 1'b0;
      perr_f_q   <= 1'b0;
      stop_err_q <= 1'b0;
      stop_one_q <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      overrun_q  <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bidx_q     <= bidx_d;
      shreg_q    <= shreg_d;
      par_bit_q  <= par_bit_d;
      perr_f_q   <= perr_f_d;
      stop_err_q <= stop_err_d;
      stop_one_q <= stop_one_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      overrun_q  <= overrun_d;
      brk_q      <= brk_d;
    end
  end

  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign ferr    = ferr_q;
  assign perr    = perr_q;
  assign overrun = overrun_q;
  assign brk     = brk_q;

endmodule
`default_nettype wire
